// File: rtl/sumador_pkg.sv
// Shared types and constants for the pipelined floating-point adder.
// Contents: default widths (SUM_E, SUM_M), exponent bias, quiet-NaN pattern,
// operand class enum and the three stage-register payload structs.
package sumador_pkg;

    localparam int unsigned SUM_E  = 8;
    localparam int unsigned SUM_M  = 23;
    localparam int unsigned SUM_W  = SUM_E + SUM_M + 1;
    // Aligned fraction: hidden bit, M mantissa bits, guard, round, sticky
    localparam int unsigned SUM_FW = SUM_M + 4;
    localparam int unsigned BIAS   = (1 << (SUM_E - 1)) - 1;

    localparam logic [SUM_W-1:0] QNAN = {1'b0, {SUM_E{1'b1}}, 1'b1, {(SUM_M-1){1'b0}}};

    typedef enum logic [1:0] {
        NORMAL,
        CERO,
        INF,
        NAN
    } clase_t;

    // Registered operand pair
    typedef struct packed {
        logic [SUM_W-1:0] a;
        logic [SUM_W-1:0] b;
    } entrada_t;

    // After alignment: X is the larger magnitude, fy already shifted
    typedef struct packed {
        clase_t            clase;
        logic              signo;
        logic              resta;
        logic [SUM_E-1:0]  exp;
        logic [SUM_FW-1:0] fx;
        logic [SUM_FW-1:0] fy;
    } alineado_t;

    // After add/subtract: one extra carry bit on top of the fraction
    typedef struct packed {
        clase_t            clase;
        logic              signo;
        logic [SUM_E-1:0]  exp;
        logic [SUM_FW:0]   suma;
    } sumado_t;

endpackage

// File: rtl/sumador_flotante_segmentado_contador_ceros.sv
// Combinational leading-zero counter.
// Ports: vec_i (W-bit vector), ceros_o (number of leading zeros, W when vec_i is 0).
module contador_ceros #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]           vec_i,
    output logic [$clog2(W+1)-1:0] ceros_o
);

    localparam int unsigned CW = $clog2(W + 1);

    // Scanning upward lets the highest set bit win
    always_comb begin : cuenta
        ceros_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (vec_i[i]) begin
                ceros_o = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/sumador_flotante_segmentado.sv
// Pipelined floating-point adder with valid/ready stream handshake.
// Stages: input register -> align -> add/subtract -> normalise/round/pack.
// Latency 3 cycles after acceptance, one operation per cycle, global stall.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   valido_in/listo_in operand handshake; a, b operands {sign, exp, mant}
//   valido_out/listo_out result handshake; s result, exp_cout overflow flag
// Build option: define SUMADOR_REDONDEO_EN for round-to-nearest-even,
// otherwise results are truncated toward zero.
module sumador_flotante_segmentado
    import sumador_pkg::*;
#(
    parameter int unsigned E = SUM_E,
    parameter int unsigned M = SUM_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valido_in,
    output logic         listo_in,
    input  logic [E+M:0] a,
    input  logic [E+M:0] b,
    output logic         valido_out,
    input  logic         listo_out,
    output logic [E+M:0] s,
    output logic         exp_cout
);

    localparam int unsigned W   = E + M + 1;
    localparam int unsigned FW  = M + 4;
    localparam int unsigned LZW = $clog2(FW + 1);
    localparam int unsigned XW  = ((E > LZW) ? E : LZW) + 2;

    // Stage structs are sized from the package widths
    if (E != SUM_E || M != SUM_M) begin : g_anchura_invalida
        $error("E/M must match SUM_E/SUM_M in sumador_pkg");
    end

    logic        avanza;
    logic        v0_q, v1_q, v2_q, vout_q;
    entrada_t    r0_q;
    alineado_t   r1_q, r1_d;
    sumado_t     r2_q, r2_d;
    logic [W-1:0] s_q, s_d;
    logic        cout_q, cout_d;

    assign avanza     = !vout_q || listo_out;
    assign listo_in   = avanza;
    assign valido_out = vout_q;
    assign s          = s_q;
    assign exp_cout   = cout_q;

    // Pipeline registers; every stage moves together
    always_ff @(posedge clk or posedge rst) begin : registros
        if (rst) begin
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            vout_q <= 1'b0;
            r0_q   <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else if (avanza) begin
            v0_q   <= valido_in;
            r0_q.a <= a;
            r0_q.b <= b;
            v1_q   <= v0_q;
            r1_q   <= r1_d;
            v2_q   <= v1_q;
            r2_q   <= r2_d;
            vout_q <= v2_q;
            s_q    <= v2_q ? s_d : '0;
            cout_q <= v2_q & cout_d;
        end
    end

    // Stage 1: classify, order by magnitude, align the smaller operand
    logic         sa, sb, sx, intercambio;
    logic [E-1:0] ea, eb, ex, ey, dif;
    logic [M-1:0] ma, mb, mx, my;
    logic         nan_a, nan_b, inf_a, inf_b, cero_a, cero_b;
    logic [FW-1:0]   fy_full;
    logic [2*FW-1:0] fy_ext;

    always_comb begin : etapa_alineacion
        r1_d = '0;
        {sa, ea, ma} = r0_q.a;
        {sb, eb, mb} = r0_q.b;
        nan_a  = (&ea) && (|ma);
        nan_b  = (&eb) && (|mb);
        inf_a  = (&ea) && !(|ma);
        inf_b  = (&eb) && !(|mb);
        cero_a = (ea == '0);
        cero_b = (eb == '0);

        intercambio = {eb, mb} > {ea, ma};
        sx  = intercambio ? sb : sa;
        ex  = intercambio ? eb : ea;
        mx  = intercambio ? mb : ma;
        ey  = intercambio ? ea : eb;
        my  = intercambio ? ma : mb;
        dif = ex - ey;

        // Exponent 0 flushes to zero, so no hidden bit
        fy_full = (ey == '0) ? '0 : {1'b1, my, 3'b000};
        // Bits shifted past the sticky position are OR-ed into it
        fy_ext  = {fy_full, FW'(0)} >> dif;

        r1_d.fx    = {1'b1, mx, 3'b000};
        r1_d.fy    = {fy_ext[2*FW-1:FW+1], fy_ext[FW] | (|fy_ext[FW-1:0])};
        r1_d.exp   = ex;
        r1_d.signo = sx;
        r1_d.resta = sa ^ sb;

        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            r1_d.clase = NAN;
            r1_d.signo = 1'b0;
        end else if (inf_a || inf_b) begin
            r1_d.clase = INF;
            r1_d.signo = inf_a ? sa : sb;
        end else if (cero_a && cero_b) begin
            r1_d.clase = CERO;
            r1_d.signo = sa & sb;
        end else begin
            r1_d.clase = NORMAL;
        end
    end

    // Stage 2: magnitude add or subtract; X >= Y so the difference is never negative
    always_comb begin : etapa_suma
        r2_d       = '0;
        r2_d.clase = r1_q.clase;
        r2_d.signo = r1_q.signo;
        r2_d.exp   = r1_q.exp;
        if (r1_q.resta) begin
            r2_d.suma = {1'b0, r1_q.fx} - {1'b0, r1_q.fy};
        end else begin
            r2_d.suma = {1'b0, r1_q.fx} + {1'b0, r1_q.fy};
        end
    end

    // Stage 3: normalise, round, detect overflow/underflow and pack
    logic [LZW-1:0] lz;
    logic [FW-1:0]  norm;
    logic [XW-1:0]  exp_n;
    logic [M:0]     mant_r;
    logic           inc, flush;

    contador_ceros #(.W(FW)) u_contador_ceros (
        .vec_i   (r2_q.suma[FW-1:0]),
        .ceros_o (lz)
    );

    always_comb begin : etapa_normalizacion
        s_d    = '0;
        cout_d = 1'b0;
        norm   = '0;
        exp_n  = '0;
        inc    = 1'b0;
        mant_r = '0;
        flush  = 1'b0;

        if (r2_q.suma[FW]) begin
            norm  = {r2_q.suma[FW:2], r2_q.suma[1] | r2_q.suma[0]};
            exp_n = XW'(r2_q.exp) + XW'(1);
        end else begin
            norm  = r2_q.suma[FW-1:0] << lz;
            exp_n = XW'(r2_q.exp) - XW'(lz);
            flush = XW'(r2_q.exp) <= XW'(lz);
        end

`ifdef SUMADOR_REDONDEO_EN
        inc = norm[2] && (norm[1] || norm[0] || norm[3]);
`endif
        // Top bit is the rounding carry; mantissa then wraps to zero
        mant_r = {1'b0, norm[FW-2:3]} + (M+1)'(inc);
        if (mant_r[M]) begin
            exp_n = exp_n + XW'(1);
        end

        case (r2_q.clase)
            NAN:  s_d = QNAN;
            INF:  s_d = {r2_q.signo, {E{1'b1}}, {M{1'b0}}};
            CERO: s_d = {r2_q.signo, (W-1)'(0)};
            default: begin
                if (norm == '0) begin
                    s_d = '0;
                end else if (flush) begin
                    s_d = {r2_q.signo, (W-1)'(0)};
                end else if (exp_n >= XW'({E{1'b1}})) begin
                    s_d    = {r2_q.signo, {E{1'b1}}, {M{1'b0}}};
                    cout_d = 1'b1;
                end else begin
                    s_d = {r2_q.signo, exp_n[E-1:0], mant_r[M-1:0]};
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sumador_flotante_segmentado.sv
// Directed self-checking bench for sumador_flotante_segmentado (E=8, M=23).
// Expected values are hand-computed single-precision results; rounding-sensitive
// vectors select their expectation from SUMADOR_REDONDEO_EN.
module tb_sumador_flotante_segmentado;
    import sumador_pkg::*;

    localparam logic [31:0] UNO = {1'b0, 8'(BIAS), 23'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valido_in = 1'b0;
    logic        listo_in;
    logic [31:0] a_r = '0;
    logic [31:0] b_r = '0;
    logic        valido_out;
    logic        listo_out = 1'b1;
    logic [31:0] s;
    logic        exp_cout;

    int n_checks = 0;
    int n_fail   = 0;

    sumador_flotante_segmentado #(.E(8), .M(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .valido_in  (valido_in),
        .listo_in   (listo_in),
        .a          (a_r),
        .b          (b_r),
        .valido_out (valido_out),
        .listo_out  (listo_out),
        .s          (s),
        .exp_cout   (exp_cout)
    );

    always #5 clk = ~clk;

    // One operation with listo_out high; lat = edges from acceptance to valido_out
    task automatic operar(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic c, output int lat);
        @(negedge clk);
        a_r = x;
        b_r = y;
        valido_in = 1'b1;
        @(negedge clk);
        valido_in = 1'b0;
        lat = 0;
        while (!valido_out && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        r = s;
        c = exp_cout;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if (valido_out !== 1'b0 || s !== 32'h0 || exp_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: valido_out=%b s=%h exp_cout=%b, required 0 0 0", valido_out, s, exp_cout);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (listo_in !== 1'b1 || valido_out !== 1'b0 || s !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release: listo_in=%b valido_out=%b s=%h, required 1 0 0", listo_in, valido_out, s);
        end
    endtask

    task automatic test_vectores(input string nombre, input int n,
                                 input logic [31:0] ta [8], input logic [31:0] tb [8],
                                 input logic [31:0] te [8], input logic tc [8]);
        logic [31:0] r;
        logic        c;
        int          lat;
        for (int i = 0; i < n; i++) begin
            operar(ta[i], tb[i], r, c, lat);
            n_checks++;
            if (r !== te[i] || c !== tc[i] || lat != 3) begin
                n_fail++;
                $display("FAIL %s[%0d] %h+%h: s=%h exp_cout=%b lat=%0d, required s=%h exp_cout=%b lat=3",
                         nombre, i, ta[i], tb[i], r, c, lat, te[i], tc[i]);
            end
        end
    endtask

    task automatic test_suma_basica;
        logic [31:0] ta [8], tb [8], te [8];
        logic        tc [8];
        ta = '{UNO,      32'h40000000, 32'h00000000, 32'h80000000, 32'h80000000, 0, 0, 0};
        tb = '{UNO,      32'h40400000, UNO,          32'h80000000, 32'h00000000, 0, 0, 0};
        te = '{32'h40000000, 32'h40A00000, UNO,      32'h80000000, 32'h00000000, 0, 0, 0};
        tc = '{0, 0, 0, 0, 0, 0, 0, 0};
        test_vectores("suma", 5, ta, tb, te, tc);
    endtask

    task automatic test_resta;
        logic [31:0] ta [8], tb [8], te [8];
        logic        tc [8];
        ta = '{UNO,          32'h40400000, 32'hC0000000, 32'hBF800000, 32'h80C00000, 0, 0, 0};
        tb = '{32'hBF800000, 32'hBF800000, UNO,          UNO,          32'h00800000, 0, 0, 0};
        te = '{32'h00000000, 32'h40000000, 32'hBF800000, 32'h00000000, 32'h80000000, 0, 0, 0};
        tc = '{0, 0, 0, 0, 0, 0, 0, 0};
        test_vectores("resta", 5, ta, tb, te, tc);
    endtask

    task automatic test_redondeo;
        logic [31:0] ta [8], tb [8], te [8];
        logic        tc [8];
        ta = '{UNO, UNO, UNO, UNO, 32'h3F800001, 32'h7F7FFFFF, 0, 0};
        tb = '{32'h34400000, 32'h33800000, 32'h30800000, 32'hB0800000, 32'h33800000, 32'h73000000, 0, 0};
`ifdef SUMADOR_REDONDEO_EN
        te = '{32'h3F800002, UNO, UNO, UNO, 32'h3F800002, 32'h7F800000, 0, 0};
        tc = '{0, 0, 0, 0, 0, 1, 0, 0};
`else
        te = '{32'h3F800001, UNO, UNO, 32'h3F7FFFFF, 32'h3F800001, 32'h7F7FFFFF, 0, 0};
        tc = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
        test_vectores("redondeo", 6, ta, tb, te, tc);
    endtask

    task automatic test_desbordamiento;
        logic [31:0] ta [8], tb [8], te [8];
        logic        tc [8];
        ta = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F000000, 32'h7E800000, 0, 0, 0, 0};
        tb = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F000000, 32'h7E800000, 0, 0, 0, 0};
        te = '{32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h7F000000, 0, 0, 0, 0};
        tc = '{1, 1, 1, 0, 0, 0, 0, 0};
        test_vectores("desborde", 4, ta, tb, te, tc);
    endtask

    task automatic test_especiales;
        logic [31:0] ta [8], tb [8], te [8];
        logic        tc [8];
        ta = '{32'h7F800000, 32'h7FC00000, UNO,          32'h7F800000, UNO,          32'h7F800000, 32'h7FC00000, 0};
        tb = '{32'hFF800000, UNO,          32'hFFC00001, UNO,          32'hFF800000, 32'h7F800000, 32'h7F800000, 0};
        te = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h7FC00000, 0};
        tc = '{0, 0, 0, 0, 0, 0, 0, 0};
        test_vectores("especial", 7, ta, tb, te, tc);
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [8], tb [8], te [8];
        logic        tc [8];
        logic [31:0] s_prev;
        logic        retenido, acepta;
        int          idx, got, ciclo;
        ta = '{UNO, 32'h40000000, 32'h40400000, 32'hC0000000, UNO, 32'h7F7FFFFF, 32'h7F800000, 32'h00000000};
        tb = '{UNO, 32'h40400000, 32'hBF800000, UNO, 32'hBF800000, 32'h7F7FFFFF, UNO, UNO};
        te = '{32'h40000000, 32'h40A00000, 32'h40000000, 32'hBF800000, 32'h00000000, 32'h7F800000, 32'h7F800000, UNO};
        tc = '{0, 0, 0, 0, 0, 1, 0, 0};
        idx = 0;
        got = 0;
        ciclo = 0;
        retenido = 1'b0;
        s_prev = '0;
        while ((idx < 8 || got < 8) && ciclo < 60) begin
            @(negedge clk);
            listo_out = !(ciclo >= 4 && ciclo <= 7);
            if (idx < 8) begin
                a_r = ta[idx];
                b_r = tb[idx];
                valido_in = 1'b1;
            end else begin
                valido_in = 1'b0;
            end
            #1;
            if (retenido) begin
                n_checks++;
                if (valido_out !== 1'b1 || s !== s_prev) begin
                    n_fail++;
                    $display("FAIL stall_hold ciclo %0d: valido_out=%b s=%h, required 1 %h", ciclo, valido_out, s, s_prev);
                end
            end
            if (ciclo >= 4 && ciclo <= 7) begin
                n_checks++;
                if (listo_in !== 1'b0 || valido_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_listo ciclo %0d: listo_in=%b valido_out=%b, required 0 1", ciclo, listo_in, valido_out);
                end
            end
            retenido = valido_out && !listo_out;
            s_prev = s;
            if (valido_out && listo_out) begin
                n_checks++;
                if (got >= 8) begin
                    n_fail++;
                    $display("FAIL stream_extra: result %h beyond 8, required none", s);
                end else if (s !== te[got] || exp_cout !== tc[got]) begin
                    n_fail++;
                    $display("FAIL stream[%0d]: s=%h exp_cout=%b, required %h %b", got, s, exp_cout, te[got], tc[got]);
                end
                got++;
            end
            acepta = valido_in && listo_in;
            @(posedge clk);
            if (acepta) idx++;
            ciclo++;
        end
        n_checks++;
        if (idx != 8 || got != 8) begin
            n_fail++;
            $display("FAIL stream_count: sent=%0d received=%0d, required 8 8", idx, got);
        end
        listo_out = 1'b1;
        valido_in = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (valido_out !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_drain: valido_out=%b s=%h, required 0", valido_out, s);
            end
        end
    endtask

    task automatic test_reset_en_vuelo;
        logic [31:0] r;
        logic        c, limpio;
        int          lat;
        listo_out = 1'b1;
        @(negedge clk);
        a_r = 32'h7F7FFFFF;
        b_r = 32'h7F7FFFFF;
        valido_in = 1'b1;
        @(negedge clk);
        a_r = UNO;
        b_r = UNO;
        @(negedge clk);
        a_r = 32'h40000000;
        b_r = 32'h40400000;
        @(negedge clk);
        valido_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valido_out !== 1'b1 || s !== 32'h7F800000 || exp_cout !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_first: valido_out=%b s=%h exp_cout=%b, required 1 7f800000 1", valido_out, s, exp_cout);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (valido_out !== 1'b0 || s !== 32'h0 || exp_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valido_out=%b s=%h exp_cout=%b, required 0 0 0", valido_out, s, exp_cout);
        end
        @(negedge clk);
        rst = 1'b0;
        limpio = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (valido_out !== 1'b0 || s !== 32'h0) limpio = 1'b0;
        end
        n_checks++;
        if (limpio !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_discard: stale result seen (last valido_out=%b s=%h), required none", valido_out, s);
        end
        operar(UNO, UNO, r, c, lat);
        n_checks++;
        if (r !== 32'h40000000 || c !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL post_reset: s=%h exp_cout=%b lat=%0d, required 40000000 0 3", r, c, lat);
        end
    endtask

    initial begin
        test_reset();
        test_suma_basica();
        test_resta();
        test_redondeo();
        test_desbordamiento();
        test_especiales();
        test_back_to_back();
        test_reset_en_vuelo();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
